vgm_player: RTL and testbench

Command-stream sequencer that drives the ym2149 register-write port from a VGM command stream held in a synchronous byte ROM. It fetches and decodes VGM opcodes (AY-3-8910/YM2149 register writes, sample waits, end-of-data) and emits edge-qualified write strobes compatible with the ym2149 `in_reg`/`in_val`/`in_wr` inputs. Wait commands are timed in 44.1 kHz sample periods derived from the system clock. It sits between the song ROM and the ym2149 instance.

---
 rtl/vgm_player.sv | 174 +++++++++++++++++
 tb/tb_vgm_player.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vgm_player.sv
// VGM command-stream sequencer: fetches opcodes from a synchronous byte ROM and drives ym2149 register writes.
// Latency: 2 cycles per byte fetch, 1 decode cycle; A0 write = 9 cycles, waits = N*SAMPLE_DIV cycles.
// Backpressure: none; the ROM answers one cycle after out_addr, in_start is ignored while busy.
module vgm_player #(
    parameter int SAMPLE_DIV = 567,
    parameter int ADDR_W     = 16,
    parameter int START_ADDR = 0
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_start,
    output logic [ADDR_W-1:0] out_addr,
    input  logic [7:0]        in_data,
    output logic [3:0]        out_reg,
    output logic [7:0]        out_val,
    output logic              out_wr,
    output logic              out_busy,
    output logic              out_done,
    output logic              out_err
);

    localparam int                DIV_W    = $clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [ADDR_W-1:0] START    = ADDR_W'(START_ADDR);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_DECODE,
        S_ARG1,
        S_ARG2,
        S_WR_HI,
        S_WR_LO,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state;
    logic [1:0]         byte_idx;   // 0: opcode, 1: first argument, 2: second argument
    logic [7:0]         op_r;
    logic [7:0]         arg1_r;
    logic [15:0]        samp_cnt;   // samples still to wait, including the current one
    logic [DIV_W-1:0]   div_cnt;    // clock cycles elapsed within the current sample

    // Sequencer: fetch/decode/execute with all outputs registered
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state    <= S_IDLE;
            byte_idx <= 2'd0;
            op_r     <= 8'd0;
            arg1_r   <= 8'd0;
            samp_cnt <= 16'd0;
            div_cnt  <= '0;
            out_addr <= START;
            out_reg  <= 4'd0;
            out_val  <= 8'd0;
            out_wr   <= 1'b0;
            out_busy <= 1'b0;
            out_done <= 1'b0;
            out_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (in_start) begin
                        state    <= S_FETCH;
                        out_addr <= START;
                        out_busy <= 1'b1;
                        out_done <= 1'b0;
                        out_err  <= 1'b0;
                    end
                end
                S_FETCH: begin
                    byte_idx <= 2'd0;
                    state    <= S_CAPTURE;
                end
                S_ARG1: begin
                    byte_idx <= 2'd1;
                    state    <= S_CAPTURE;
                end
                S_ARG2: begin
                    byte_idx <= 2'd2;
                    state    <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    out_addr <= out_addr + ADDR_W'(1);
                    case (byte_idx)
                        2'd0: begin
                            op_r  <= in_data;
                            state <= S_DECODE;
                        end
                        2'd1: begin
                            arg1_r <= in_data;
                            state  <= S_ARG2;
                        end
                        default: begin
                            if (op_r == 8'hA0) begin
                                // Only chip 0, registers 0..15 are forwarded; others are consumed silently
                                if (arg1_r[7:4] == 4'h0) begin
                                    out_reg <= arg1_r[3:0];
                                    out_val <= in_data;
                                    out_wr  <= 1'b1;
                                    state   <= S_WR_HI;
                                end else begin
                                    state <= S_FETCH;
                                end
                            end else if ({in_data, arg1_r} == 16'd0) begin
                                state <= S_FETCH;
                            end else begin
                                samp_cnt <= {in_data, arg1_r};
                                div_cnt  <= '0;
                                state    <= S_WAIT;
                            end
                        end
                    endcase
                end
                S_DECODE: begin
                    case (op_r)
                        8'hA0, 8'h61: state <= S_ARG1;
                        8'h62: begin
                            samp_cnt <= 16'd735;
                            div_cnt  <= '0;
                            state    <= S_WAIT;
                        end
                        8'h63: begin
                            samp_cnt <= 16'd882;
                            div_cnt  <= '0;
                            state    <= S_WAIT;
                        end
                        8'h66: begin
                            out_busy <= 1'b0;
                            out_done <= 1'b1;
                            state    <= S_DONE;
                        end
                        default: begin
                            if (op_r[7:4] == 4'h7) begin
                                samp_cnt <= {12'd0, op_r[3:0]} + 16'd1;
                                div_cnt  <= '0;
                                state    <= S_WAIT;
                            end else begin
                                out_busy <= 1'b0;
                                out_err  <= 1'b1;
                                state    <= S_ERR;
                            end
                        end
                    endcase
                end
                S_WR_HI: begin
                    out_wr <= 1'b0;
                    state  <= S_WR_LO;
                end
                S_WR_LO: begin
                    state <= S_FETCH;
                end
                S_WAIT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (samp_cnt == 16'd1) begin
                            samp_cnt <= 16'd0;
                            state    <= S_FETCH;
                        end else begin
                            samp_cnt <= samp_cnt - 16'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vgm_player.sv
// Bench for vgm_player: a command-level timing model predicts every write edge and the end state.
// Latency: outputs compared every cycle of each run against the model.
// Backpressure: none; the ROM model answers one cycle after out_addr.
module tb_vgm_player;

    localparam int SD = 4;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        in_start;
    logic [15:0] out_addr;
    logic [7:0]  in_data;
    logic [3:0]  out_reg;
    logic [7:0]  out_val;
    logic        out_wr;
    logic        out_busy;
    logic        out_done;
    logic        out_err;

    vgm_player #(.SAMPLE_DIV(SD), .ADDR_W(16), .START_ADDR(0)) dut (
        .in_clk   (in_clk),
        .in_rst   (in_rst),
        .in_start (in_start),
        .out_addr (out_addr),
        .in_data  (in_data),
        .out_reg  (out_reg),
        .out_val  (out_val),
        .out_wr   (out_wr),
        .out_busy (out_busy),
        .out_done (out_done),
        .out_err  (out_err)
    );

    always #5 in_clk = ~in_clk;

    // Synchronous byte ROM
    logic [7:0] rom [0:255];
    always @(posedge in_clk) in_data <= rom[out_addr[7:0]];

    int total = 0;
    int bad   = 0;

    // Model results for the current stream
    int         exp_wt[$];
    logic [3:0] exp_reg[$];
    logic [7:0] exp_val[$];
    int         exp_end;
    bit         exp_done;
    int         exp_addr;
    logic [3:0] base_reg = 4'd0;
    logic [7:0] base_val = 8'd0;

    // Compare process state
    bit   chk_en = 1'b0;
    int   cyc = 0;
    int   rise_t[$];
    logic prev_wr = 1'b0;

    task automatic load(input int n, input logic [8*24-1:0] bytes);
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        for (int i = 0; i < n; i++) rom[i] = bytes[(n-1-i)*8 +: 8];
    endtask

    // Walk the command stream and derive write edges and end state from the command timings
    task automatic build_model();
        int pc, t;
        bit fin;
        logic [7:0] op, a1, a2;
        exp_wt.delete(); exp_reg.delete(); exp_val.delete();
        pc = 0; t = 0; fin = 1'b0;
        exp_end = 0; exp_done = 1'b0; exp_addr = 0;
        for (int g = 0; g < 64 && !fin; g++) begin
            op = rom[pc & 255]; a1 = rom[(pc+1) & 255]; a2 = rom[(pc+2) & 255];
            if (op == 8'hA0) begin
                if (a1[7:4] == 4'h0) begin
                    exp_wt.push_back(t + 7); exp_reg.push_back(a1[3:0]); exp_val.push_back(a2);
                    t += 9;
                end else t += 7;
                pc += 3;
            end else if (op == 8'h61) begin
                t += 7 + int'({a2, a1}) * SD; pc += 3;
            end else if (op == 8'h62) begin
                t += 3 + 735 * SD; pc += 1;
            end else if (op == 8'h63) begin
                t += 3 + 882 * SD; pc += 1;
            end else if (op[7:4] == 4'h7) begin
                t += 3 + (int'(op[3:0]) + 1) * SD; pc += 1;
            end else begin
                exp_end = t + 3; exp_done = (op == 8'h66); exp_addr = pc + 1; fin = 1'b1;
            end
        end
    endtask

    // Per-cycle check of all outputs against the model (cyc 0 = cycle after the start edge)
    always @(negedge in_clk) begin
        logic       e_wr, e_busy, e_done, e_err, addr_ok;
        logic [3:0] e_reg;
        logic [7:0] e_val;
        if (chk_en) begin
            e_wr = 1'b0; e_reg = base_reg; e_val = base_val;
            for (int i = 0; i < exp_wt.size(); i++) begin
                if (exp_wt[i] == cyc) e_wr = 1'b1;
                if (exp_wt[i] <= cyc) begin e_reg = exp_reg[i]; e_val = exp_val[i]; end
            end
            e_busy = (cyc < exp_end);
            e_done = !e_busy && exp_done;
            e_err  = !e_busy && !exp_done;
            addr_ok = 1'b1;
            if (cyc == 0) addr_ok = (out_addr === 16'd0);
            else if (!e_busy) addr_ok = (out_addr === 16'(exp_addr));
            total++;
            if (out_wr !== e_wr || out_reg !== e_reg || out_val !== e_val || out_busy !== e_busy ||
                out_done !== e_done || out_err !== e_err || !addr_ok) begin
                bad++;
                $display("FAIL cycle_outputs cyc=%0d got wr=%b reg=%h val=%h busy=%b done=%b err=%b addr=%h expected wr=%b reg=%h val=%h busy=%b done=%b err=%b addr=%h",
                         cyc, out_wr, out_reg, out_val, out_busy, out_done, out_err, out_addr,
                         e_wr, e_reg, e_val, e_busy, e_done, e_err, (cyc == 0) ? 16'd0 : 16'(exp_addr));
            end
            if (out_wr === 1'b1 && prev_wr !== 1'b1) rise_t.push_back(cyc);
            prev_wr = out_wr;
            cyc++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int spacing(input int i);
        if (rise_t.size() > i + 1) return rise_t[i+1] - rise_t[i];
        return -1;
    endfunction

    task automatic chk_reset_vals(input string name);
        total++;
        if (out_addr !== 16'd0 || out_reg !== 4'd0 || out_val !== 8'd0 || out_wr !== 1'b0 ||
            out_busy !== 1'b0 || out_done !== 1'b0 || out_err !== 1'b0) begin
            bad++;
            $display("FAIL %s got addr=%h reg=%h val=%h wr=%b busy=%b done=%b err=%b expected all zero",
                     name, out_addr, out_reg, out_val, out_wr, out_busy, out_done, out_err);
        end
    endtask

    // Start the current ROM and check every cycle until a few cycles past the model's end
    task automatic run(input bit mid_pulse);
        build_model();
        rise_t.delete();
        prev_wr = 1'b0;
        @(negedge in_clk); in_start = 1'b1;
        @(posedge in_clk); #1 in_start = 1'b0;
        cyc = 0; chk_en = 1'b1;
        while (cyc <= exp_end + 4) begin
            @(negedge in_clk); #1;
            if (mid_pulse) in_start = (cyc == 4);
        end
        in_start = 1'b0;
        chk_en = 1'b0;
        if (exp_wt.size() > 0) begin
            base_reg = exp_reg[exp_wt.size()-1];
            base_val = exp_val[exp_wt.size()-1];
        end
    endtask

    // Start without per-cycle checking, hit reset either on the first write strobe or after a delay
    task automatic reset_mid(input string name, input bit on_wr, input int delay);
        bit seen;
        @(negedge in_clk); in_start = 1'b1;
        @(posedge in_clk); #1 in_start = 1'b0;
        seen = 1'b0;
        if (on_wr) begin
            for (int k = 0; k < 200 && !seen; k++) begin
                @(negedge in_clk);
                if (out_wr === 1'b1) seen = 1'b1;
            end
            chk({name, "_wr_seen"}, int'(seen), 1);
        end else begin
            repeat (delay) @(negedge in_clk);
            chk({name, "_busy_before"}, int'(out_busy), 1);
        end
        in_rst = 1'b1;
        @(posedge in_clk); #1;
        chk_reset_vals({name, "_reset_vals"});
        @(negedge in_clk); in_rst = 1'b0;
        base_reg = 4'd0; base_val = 8'd0;
    endtask

    initial begin
        in_rst = 1'b1; in_start = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        repeat (3) @(posedge in_clk);
        #1 chk_reset_vals("reset_state");
        @(negedge in_clk); in_rst = 1'b0;

        // Two consecutive writes then end-of-data
        load(7, {8'hA0, 8'h07, 8'h38, 8'hA0, 8'h08, 8'h0F, 8'h66});
        run(1'b0);
        chk("w_model_end", exp_end, 21);
        chk("w_model_addr", exp_addr, 7);
        chk("w_rises", rise_t.size(), 2);
        chk("w_spacing", spacing(0), 9);
        chk("w_done", int'(out_done), 1);

        // Short wait 0x7F between writes; in_start pulsed mid-run must be ignored
        load(8, {8'hA0, 8'h00, 8'h01, 8'h7F, 8'hA0, 8'h00, 8'h02, 8'h66});
        run(1'b1);
        chk("sw_spacing", spacing(0), 76);
        chk("sw_model_addr", exp_addr, 8);

        // 16-bit waits, non-zero and zero
        load(16, {8'hA0, 8'h00, 8'h01, 8'h61, 8'h03, 8'h00, 8'hA0, 8'h00, 8'h02,
                  8'h61, 8'h00, 8'h00, 8'hA0, 8'h00, 8'h03, 8'h66});
        run(1'b0);
        chk("lw_rises", rise_t.size(), 3);
        chk("lw_spacing_3", spacing(0), 7 + 12 + 9);
        chk("lw_spacing_0", spacing(1), 7 + 9);
        chk("lw_model_end", exp_end, 56);

        // Fixed 735/882-sample waits
        load(12, {8'hA0, 8'h00, 8'h01, 8'h62, 8'hA0, 8'h00, 8'h02, 8'h63, 8'hA0, 8'h00, 8'h03, 8'h66});
        run(1'b0);
        chk("fw_spacing_62", spacing(0), 2 + 3 + 735 * SD + 7);
        chk("fw_spacing_63", spacing(1), 2 + 3 + 882 * SD + 7);

        // Skipped second-chip write then unknown opcode; replay from ERR
        load(4, {8'hA0, 8'h15, 8'hAA, 8'h4F});
        run(1'b0);
        chk("err_rises", rise_t.size(), 0);
        chk("err_model_addr", exp_addr, 4);
        chk("err_flag", int'(out_err), 1);
        run(1'b0);
        chk("err_replay_rises", rise_t.size(), 0);

        // Reset during WR_HI, then full replay
        load(7, {8'hA0, 8'h07, 8'h38, 8'hA0, 8'h08, 8'h0F, 8'h66});
        reset_mid("rst_wrhi", 1'b1, 0);
        run(1'b0);
        chk("rst_wrhi_replay_spacing", spacing(0), 9);

        // Reset during WAIT, then full replay
        load(8, {8'hA0, 8'h00, 8'h01, 8'h7F, 8'hA0, 8'h00, 8'h02, 8'h66});
        reset_mid("rst_wait", 1'b0, 30);
        run(1'b0);
        chk("rst_wait_replay_spacing", spacing(0), 76);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
